uart_debug_streamer: RTL

//   Buffers debug words from the CPU in a DEPTH-entry FIFO and drains them to uart_tx one byte at a time.

---
 rtl/uart_dbg_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_debug_streamer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_dbg_pkg.sv
// uart_dbg_pkg: shared FSM states, ASCII constants and nibble-to-hex helper for the UART debug path
package uart_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3,
        NEXT = 3'd4
    } state_t;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_A  = 8'h41;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? ASC_0 + {4'd0, n} : ASC_A + {4'd0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: register-array FIFO with wrapping pointers and an occupancy count
//   clk, resetn      clock, asynchronous active-low reset
//   wr_en, wr_data   push request and data (ignored while full)
//   rd_en, rd_data   pop request and head-of-queue data (ignored while empty)
//   level            occupancy 0..DEPTH
//   full, empty      level==DEPTH, level==0
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push, pop;

    always_comb begin
        push     = wr_en && !full;
        pop      = rd_en && !empty;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;
    assign full    = level_q == LVL_FULL;
    assign empty   = level_q == '0;

endmodule

// File: rtl/uart_debug_streamer.sv
// uart_debug_streamer: buffers CPU debug words and drains them to uart_tx as raw bytes or ASCII hex lines
//   clk, resetn           clock, asynchronous active-low reset
//   wr_data, wr_valid     debug word and push request from the CPU
//   wr_ready              FIFO not full
//   level, drop_count     FIFO occupancy, saturating count of pushes lost while full
//   busy                  word in flight or FIFO non-empty
//   tx_byte, tx_dv        byte and one-cycle start pulse to uart_tx
//   tx_active, tx_done    uart_tx status: transmitting, byte finished
module uart_debug_streamer
    import uart_dbg_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int DEPTH    = 16,
    parameter int HEX_MODE = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [WORD_W-1:0]      wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            drop_count,
    output logic                   busy,
    output logic [7:0]             tx_byte,
    output logic                   tx_dv,
    input  logic                   tx_active,
    input  logic                   tx_done
);
    localparam int NSYM = (HEX_MODE != 0) ? WORD_W / 4 + 2 : WORD_W / 8;
    localparam int CW   = $clog2(NSYM + 1);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sh_q, sh_d, head;
    logic [CW-1:0]     sym_q, sym_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_dv_q, tx_dv_d;
    logic [15:0]       drop_q, drop_d;
    logic              pop, full, empty;

    // Symbol k of word w: shift the wanted field to the top, then pick it.
    function automatic logic [7:0] symbol(input logic [WORD_W-1:0] w, input logic [CW-1:0] k);
        logic [WORD_W-1:0] s;
        if (HEX_MODE != 0) begin
            s = w << {k, 2'b00};
            return (int'(k) == NSYM - 2) ? ASC_CR :
                   (int'(k) == NSYM - 1) ? ASC_LF : hex_ascii(s[WORD_W-1 -: 4]);
        end
        s = w << {k, 3'b000};
        return s[WORD_W-1 -: 8];
    endfunction

    sync_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_valid),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    // tx_byte/tx_dv are registered, so they are computed on the transition into SEND.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        sym_d     = sym_q;
        tx_byte_d = tx_byte_q;
        tx_dv_d   = 1'b0;
        pop       = 1'b0;
        drop_d    = (wr_valid && full && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        case (state_q)
            IDLE: state_d = (!empty && !tx_active) ? LOAD : IDLE;
            LOAD: begin
                pop       = 1'b1;
                sh_d      = head;
                sym_d     = '0;
                tx_byte_d = symbol(head, '0);
                tx_dv_d   = 1'b1;
                state_d   = SEND;
            end
            SEND: state_d = WAIT;
            WAIT: state_d = tx_done ? NEXT : WAIT;
            NEXT: begin
                if (int'(sym_q) == NSYM - 1) begin
                    state_d = IDLE;
                end else begin
                    sym_d     = sym_q + CW'(1);
                    tx_byte_d = symbol(sh_q, sym_q + CW'(1));
                    tx_dv_d   = 1'b1;
                    state_d   = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            sym_q     <= '0;
            tx_byte_q <= '0;
            tx_dv_q   <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            sym_q     <= sym_d;
            tx_byte_q <= tx_byte_d;
            tx_dv_q   <= tx_dv_d;
            drop_q    <= drop_d;
        end
    end

    assign wr_ready   = !full;
    assign busy       = (state_q != IDLE) || !empty;
    assign tx_byte    = tx_byte_q;
    assign tx_dv      = tx_dv_q;
    assign drop_count = drop_q;

endmodule
